// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sched_pkg
// Description : Shared state encoding and default sizing for the FIFO burst
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } sched_st_t;

    localparam int c_DEF_DW      = 16;
    localparam int c_DEF_AW      = 8;
    localparam int c_DEF_BURST   = 64;
    localparam int c_DEF_GAP_CYC = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_sched
// Description : Fills an external FIFO with one bounded burst, waits a settle
//               gap, then drains exactly that burst to the sink.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_sched
    import fifo_sched_pkg::*;
#(
    parameter int DW      = c_DEF_DW,
    parameter int AW      = c_DEF_AW,
    parameter int BURST   = c_DEF_BURST,
    parameter int GAP_CYC = c_DEF_GAP_CYC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [DW-1:0]                  src_data,
    input  logic                           src_valid,
    output logic                           src_ready,
    output logic                           fifo_wr_en,
    output logic [DW-1:0]                  fifo_wr_data,
    input  logic                           fifo_full,
    input  logic                           fifo_empty,
    input  logic [AW-1:0]                  fifo_usedw,
    output logic                           fifo_rd_en,
    input  logic [DW-1:0]                  fifo_rd_data,
    output logic [DW-1:0]                  snk_data,
    output logic                           snk_valid,
    output logic                           burst_done,
    output logic [$clog2(BURST+1)-1:0]     burst_len,
    output logic                           underrun_err,
    output logic [1:0]                     state_o,
    output logic [AW-1:0]                  dbg_usedw
);

    localparam int c_CW = $clog2(BURST + 1);
    localparam int c_GW = $clog2(GAP_CYC + 1);
    localparam logic [c_CW-1:0] c_BURST_LAST = c_CW'(BURST - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(GAP_CYC - 1);

    sched_st_t       r_state;
    sched_st_t       w_state_nxt;
    logic [c_CW-1:0] r_wr_cnt;
    logic [c_CW-1:0] r_rd_cnt;
    logic [c_GW-1:0] r_gap_cnt;
    logic            w_gap_end;
    logic            w_drain_end;
    logic            w_underrun;

    assign fifo_wr_en   = src_valid & src_ready;
    assign fifo_wr_data = src_data;
    assign state_o      = r_state;

    // src_ready is combinational so it drops in the very cycle FILL is left,
    // which is what keeps a burst from ever exceeding BURST words.
    always_comb begin
        w_state_nxt = r_state;
        src_ready   = 1'b0;
        fifo_rd_en  = 1'b0;
        w_gap_end   = 1'b0;
        w_drain_end = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                src_ready = enable & ~fifo_full;
                if (!enable || (fifo_full && r_wr_cnt != '0) ||
                    (src_valid && !fifo_full && r_wr_cnt == c_BURST_LAST)) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_gap_end   = 1'b1;
                    w_state_nxt = (r_wr_cnt != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                fifo_rd_en = ~fifo_empty & (r_rd_cnt < r_wr_cnt);
                w_underrun = fifo_empty & (r_rd_cnt < r_wr_cnt);
                if ((fifo_rd_en && (r_rd_cnt + 1'b1 == r_wr_cnt)) || w_underrun) begin
                    w_drain_end = 1'b1;
                    w_state_nxt = enable ? FILL : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_gap_cnt    <= '0;
            burst_len    <= '0;
            snk_data     <= '0;
            snk_valid    <= 1'b0;
            burst_done   <= 1'b0;
            underrun_err <= 1'b0;
            dbg_usedw    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            snk_valid  <= fifo_rd_en;
            burst_done <= w_drain_end;
            dbg_usedw  <= fifo_usedw;

            if (r_state == FILL && fifo_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end else if (w_state_nxt == FILL && r_state != FILL) begin
                r_wr_cnt <= '0;
            end

            if (r_state == GAP && !w_gap_end) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_gap_end) begin
                r_rd_cnt  <= '0;
                burst_len <= r_wr_cnt;
            end else if (fifo_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            // FIFO runs in show-ahead mode: the head word is on fifo_rd_data
            // while fifo_rd_en pops it, so the sink trails the read by one cycle.
            if (fifo_rd_en) begin
                snk_data <= fifo_rd_data;
            end

            if (w_underrun) begin
                underrun_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_sched
// Description : Self-checking bench for fifo_burst_sched with a show-ahead
//               FIFO model and a write-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_sched;

    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int BURST   = 8;
    localparam int GAP_CYC = 4;
    localparam int DEPTH   = 1 << AW;
    localparam int CW      = $clog2(BURST + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready, fifo_wr_en, fifo_rd_en, snk_valid, burst_done, underrun_err;
    logic [DW-1:0] fifo_wr_data, snk_data;
    logic          fifo_full, fifo_empty;
    logic [AW-1:0] fifo_usedw, dbg_usedw;
    logic [DW-1:0] fifo_rd_data;
    logic [CW-1:0] burst_len;
    logic [1:0]    state_o;

    fifo_burst_sched #(.DW(DW), .AW(AW), .BURST(BURST), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .snk_data(snk_data), .snk_valid(snk_valid), .burst_done(burst_done),
        .burst_len(burst_len), .underrun_err(underrun_err), .state_o(state_o),
        .dbg_usedw(dbg_usedw)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: strobes seen mid-cycle commit just after the edge.
    logic [DW-1:0] fq[$];
    int            fq_cnt = 0;
    logic [DW-1:0] fq_head = '0;
    logic          p_wr = 1'b0, p_rd = 1'b0, flush_req = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          force_full = 1'b0, force_empty = 1'b0;

    assign fifo_full    = (fq_cnt >= DEPTH) || force_full;
    assign fifo_empty   = (fq_cnt == 0) || force_empty;
    assign fifo_rd_data = fq_head;
    assign fifo_usedw   = AW'(fq_cnt);

    always @(negedge clk) begin
        p_wr   = fifo_wr_en;
        p_rd   = fifo_rd_en;
        p_data = fifo_wr_data;
    end

    always @(posedge clk) begin
        #1;
        if (p_rd && fq.size() > 0) void'(fq.pop_front());
        if (p_wr) fq.push_back(p_data);
        if (flush_req) begin
            fq.delete();
            flush_req = 1'b0;
        end
        fq_cnt  = fq.size();
        fq_head = (fq.size() > 0) ? fq[0] : '0;
    end

    // Scoreboard: every drained word must be the oldest word written.
    logic [DW-1:0] sb_q[$];
    int cyc = 0, n_wr = 0, n_rd = 0, n_snk = 0, n_done = 0, n_done_with_snk = 0;
    int last_wr_cyc = 0, first_rd_cyc = -1, last_snk_cyc = -1, done_cyc = -2;
    int wr_before_drain = 0, gap_seen = 0, order_err = 0, n_bad_len = 0;

    always @(negedge clk) begin
        cyc++;
        if (fifo_wr_en) begin
            n_wr++;
            sb_q.push_back(fifo_wr_data);
            last_wr_cyc = cyc;
        end
        if (fifo_rd_en) begin
            n_rd++;
            if (first_rd_cyc < 0) begin
                first_rd_cyc    = cyc;
                wr_before_drain = n_wr;
                gap_seen        = cyc - last_wr_cyc - 1;
            end
        end
        if (snk_valid) begin
            n_snk++;
            last_snk_cyc = cyc;
            if (sb_q.size() == 0) order_err++;
            else begin
                if (sb_q[0] !== snk_data) order_err++;
                void'(sb_q.pop_front());
            end
        end
        if (burst_done) begin
            n_done++;
            done_cyc = cyc;
            if (snk_valid) n_done_with_snk++;
            if (burst_len !== CW'(BURST)) n_bad_len++;
        end
    end

    int  errors = 0;
    int  checks = 0;
    bit  rand_mode = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            src_valid = 1'($urandom_range(0, 1));
            src_data  = DW'($urandom % 256);
        end else begin
            src_data = src_data + 1'b1;
        end
    endtask

    task automatic clear_logs();
        n_wr = 0; n_rd = 0; n_snk = 0; n_done = 0; n_done_with_snk = 0;
        first_rd_cyc = -1; last_snk_cyc = -1; done_cyc = -2;
        wr_before_drain = 0; gap_seen = 0; order_err = 0; n_bad_len = 0;
        sb_q.delete();
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int t = 0;
        while (n_done < target && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (n_done < target) begin
            errors++;
            $display("FAIL %s timeout: done=%0d required=%0d", tag, n_done, target);
        end
    endtask

    task automatic finish_bursts(input string tag);
        int t = 0;
        rand_mode = 1'b0;
        enable    = 1'b0;
        src_valid = 1'b0;
        tick();
        while (state_o !== 2'd0 && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL %s idle timeout: state=%0d required=0", tag, state_o);
        end
        tick();
        tick();
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        tick();
        tick();
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({src_ready, fifo_wr_en, fifo_rd_en, snk_valid, burst_done, underrun_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000",
                     {src_ready, fifo_wr_en, fifo_rd_en, snk_valid, burst_done, underrun_err});
        end
        checks++;
        if (state_o !== 2'd0 || burst_len !== '0 || snk_data !== '0) begin
            errors++;
            $display("FAIL reset_regs state=%0d len=%0d snk=%0h required 0/0/0", state_o, burst_len, snk_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic test_full_burst();
        clear_logs();
        src_valid = 1'b1;
        enable    = 1'b1;
        wait_done(1, 200, "full_burst");
        checks++;
        if (wr_before_drain !== BURST) begin
            errors++;
            $display("FAIL full_writes got=%0d required=%0d", wr_before_drain, BURST);
        end
        checks++;
        if (gap_seen !== GAP_CYC) begin
            errors++;
            $display("FAIL full_gap got=%0d required=%0d", gap_seen, GAP_CYC);
        end
        checks++;
        if (n_snk !== BURST || order_err !== 0) begin
            errors++;
            $display("FAIL full_drain snk=%0d order_err=%0d required %0d/0", n_snk, order_err, BURST);
        end
        checks++;
        if (n_done !== 1 || n_done_with_snk !== 1 || done_cyc !== last_snk_cyc) begin
            errors++;
            $display("FAIL full_done cnt=%0d with_snk=%0d done_cyc=%0d last_snk=%0d required 1/1/equal",
                     n_done, n_done_with_snk, done_cyc, last_snk_cyc);
        end
        checks++;
        if (burst_len !== CW'(BURST) || state_o !== 2'd1) begin
            errors++;
            $display("FAIL full_next len=%0d state=%0d required %0d/1", burst_len, state_o, BURST);
        end
        finish_bursts("full_burst");
        flush_fifo();
    endtask

    task automatic test_fifo_full();
        int t = 0;
        clear_logs();
        src_valid = 1'b1;
        enable    = 1'b1;
        while (n_wr < 5 && t < 100) begin
            tick();
            t++;
        end
        force_full = 1'b1;
        @(negedge clk);
        checks++;
        if (src_ready !== 1'b0 || fifo_wr_en !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL full_flag rdy=%b wr=%b state=%0d required 0/0/1", src_ready, fifo_wr_en, state_o);
        end
        tick();
        force_full = 1'b0;
        wait_done(1, 200, "fifo_full");
        checks++;
        if (burst_len !== CW'(5) || wr_before_drain !== 5) begin
            errors++;
            $display("FAIL full_len len=%0d writes=%0d required 5/5", burst_len, wr_before_drain);
        end
        checks++;
        if (n_snk !== 5 || order_err !== 0) begin
            errors++;
            $display("FAIL full_reads snk=%0d order_err=%0d required 5/0", n_snk, order_err);
        end
        finish_bursts("fifo_full");
        flush_fifo();
    endtask

    task automatic test_enable_drop();
        int t = 0;
        clear_logs();
        src_valid = 1'b1;
        enable    = 1'b1;
        while (n_wr < 3 && t < 100) begin
            tick();
            t++;
        end
        enable = 1'b0;
        wait_done(1, 200, "enable_drop");
        tick();
        tick();
        checks++;
        if (burst_len !== CW'(3) || n_snk !== 3 || order_err !== 0) begin
            errors++;
            $display("FAIL partial len=%0d snk=%0d order_err=%0d required 3/3/0", burst_len, n_snk, order_err);
        end
        checks++;
        if (state_o !== 2'd0 || n_wr !== 3 || n_done !== 1) begin
            errors++;
            $display("FAIL partial_idle state=%0d writes=%0d done=%0d required 0/3/1", state_o, n_wr, n_done);
        end
        finish_bursts("enable_drop");
        flush_fifo();
    endtask

    task automatic test_underrun();
        int t = 0;
        clear_logs();
        src_valid = 1'b1;
        enable    = 1'b1;
        while (n_rd < 2 && t < 200) begin
            tick();
            t++;
        end
        force_empty = 1'b1;
        enable      = 1'b0;
        src_valid   = 1'b0;
        wait_done(1, 50, "underrun");
        checks++;
        if (underrun_err !== 1'b1 || n_snk !== 2 || order_err !== 0) begin
            errors++;
            $display("FAIL underrun err=%b snk=%0d order_err=%0d required 1/2/0", underrun_err, n_snk, order_err);
        end
        checks++;
        if (n_done !== 1 || n_done_with_snk !== 0) begin
            errors++;
            $display("FAIL underrun_done cnt=%0d with_snk=%0d required 1/0", n_done, n_done_with_snk);
        end
        for (int i = 0; i < 5; i++) tick();
        force_empty = 1'b0;
        tick();
        checks++;
        if (underrun_err !== 1'b1 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL underrun_sticky err=%b state=%0d required 1/0", underrun_err, state_o);
        end
        flush_fifo();
    endtask

    task automatic test_reset_mid_drain();
        int t = 0;
        clear_logs();
        src_valid = 1'b1;
        enable    = 1'b1;
        while (n_rd < 3 && t < 200) begin
            tick();
            t++;
        end
        rst_n     = 1'b0;
        enable    = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, snk_valid, burst_done, underrun_err, src_ready} !== 5'b0 ||
            state_o !== 2'd0 || burst_len !== '0 || snk_data !== '0) begin
            errors++;
            $display("FAIL mid_reset flags=%b state=%0d len=%0d snk=%0h required 0",
                     {fifo_rd_en, snk_valid, burst_done, underrun_err, src_ready}, state_o, burst_len, snk_data);
        end
        tick();
        rst_n = 1'b1;
        flush_fifo();
        src_valid = 1'b1;
        enable    = 1'b1;
        wait_done(1, 200, "restart");
        checks++;
        if (n_snk !== BURST || order_err !== 0 || burst_len !== CW'(BURST)) begin
            errors++;
            $display("FAIL restart snk=%0d order_err=%0d len=%0d required %0d/0/%0d",
                     n_snk, order_err, burst_len, BURST, BURST);
        end
        finish_bursts("restart");
        flush_fifo();
    endtask

    task automatic test_random();
        int bad_len_snap;
        clear_logs();
        rand_mode = 1'b1;
        enable    = 1'b1;
        wait_done(4, 2000, "random");
        bad_len_snap = n_bad_len;
        finish_bursts("random");
        checks++;
        if (order_err !== 0 || n_snk !== n_wr || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL random_sb order_err=%0d snk=%0d wr=%0d left=%0d required 0/equal/0",
                     order_err, n_snk, n_wr, sb_q.size());
        end
        checks++;
        if (bad_len_snap !== 0 || underrun_err !== 1'b0) begin
            errors++;
            $display("FAIL random_len bad_len=%0d underrun=%b required 0/0", bad_len_snap, underrun_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_fifo_full();
        test_enable_drop();
        test_underrun();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
